// File: rtl/pcie_tx_link_scheduler_pkg.sv
// Shared types and constants for the PCIe transmit link scheduler.
package pcie_tx_link_scheduler_pkg;

    localparam int unsigned SYM_W      = 8;
    localparam int unsigned DLLP_W     = 48;
    localparam int unsigned DLLP_BYTES = 6;
    localparam int unsigned SEQ_W      = 3;

    // 8b/10b control symbols and logical idle
    localparam logic [SYM_W-1:0] K_COM  = 8'hBC;  // K28.5
    localparam logic [SYM_W-1:0] K_STP  = 8'hFB;  // K27.7
    localparam logic [SYM_W-1:0] K_SDP  = 8'h5C;  // K28.2
    localparam logic [SYM_W-1:0] K_END  = 8'hFD;  // K29.7
    localparam logic [SYM_W-1:0] K_EDB  = 8'hFE;  // K30.7
    localparam logic [SYM_W-1:0] K_SKP  = 8'h1C;  // K28.0
    localparam logic [SYM_W-1:0] D_IDLE = 8'h00;  // D0.0

    // DLLP type codes carried in the first DLLP byte
    typedef enum logic [7:0] {
        DLLP_ACK          = 8'h00,
        DLLP_NAK          = 8'h10,
        DLLP_PM_ENTER_L1  = 8'h20,
        DLLP_PM_ENTER_L23 = 8'h21,
        DLLP_PM_REQ_ACK   = 8'h24,
        DLLP_VENDOR       = 8'h30,
        DLLP_INITFC1_P    = 8'h40,
        DLLP_INITFC1_NP   = 8'h50,
        DLLP_INITFC1_CPL  = 8'h60,
        DLLP_UPDATEFC_P   = 8'h80,
        DLLP_INITFC2_P    = 8'hC0
    } dllp_type_e;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKP_OS,
        ST_DLLP,
        ST_TLP_STP,
        ST_TLP_DATA,
        ST_TLP_END,
        ST_TLP_FLUSH
    } sched_state_e;

    // One transmit symbol towards the encoder
    typedef struct packed {
        logic [SYM_W-1:0] data;
        logic             k;
    } tx_sym_t;

endpackage

// File: rtl/pcie_skp_timer.sv
// SKP ordered-set interval timer: raises a single pending request per expiry.
module pcie_skp_timer #(
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    input  logic skp_taken,
    output logic skp_pending
);

    localparam int unsigned CNT_W = $clog2(SKP_INTERVAL + 1);

    logic [CNT_W-1:0] cnt;
    logic             expire_c;

    assign expire_c = en && (cnt == CNT_W'(SKP_INTERVAL - 1));

    // Interval counter and pending flag; a new expiry wins over a same-cycle take
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
        end else if (clear) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
        end else begin
            if (en) begin
                cnt <= expire_c ? '0 : cnt + CNT_W'(1);
            end
            if (expire_c) begin
                skp_pending <= 1'b1;
            end else if (skp_taken) begin
                skp_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcie_tx_link_scheduler.sv
// Single-lane TX scheduler: arbitrates SKP > DLLP > TLP at packet boundaries
// and frames the chosen source into one registered symbol per clock.
module pcie_tx_link_scheduler
    import pcie_tx_link_scheduler_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_COUNT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_up,
    input  logic              tlp_valid,
    input  logic [SYM_W-1:0]  tlp_data,
    input  logic              tlp_last,
    input  logic              tlp_bad,
    output logic              tlp_ready,
    input  logic              dllp_valid,
    input  logic [DLLP_W-1:0] dllp_data,
    output logic              dllp_ack,
    output logic [SYM_W-1:0]  tx_data,
    output logic              tx_k,
    output logic              skp_sent,
    output logic              tlp_underrun
);

    localparam logic [SEQ_W-1:0] SKP_LAST  = SEQ_W'(SKP_COUNT);
    localparam logic [SEQ_W-1:0] DLLP_LAST = SEQ_W'(DLLP_BYTES + 1);

    sched_state_e      state, state_nxt, cur_c;
    logic [SEQ_W-1:0]  seq, seq_nxt;
    logic [DLLP_W-1:0] dllp_q, dllp_q_nxt;
    logic [SYM_W-1:0]  term_q, term_nxt;
    tx_sym_t           sym_nxt;
    logic              ack_nxt, skp_sent_nxt, under_nxt, ready_nxt;
    logic              skp_taken, skp_pending;

    pcie_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (link_up),
        .clear       (!link_up),
        .skp_taken   (skp_taken),
        .skp_pending (skp_pending)
    );

    // Next-state and symbol selection; IDLE resolves to the winning source in the same cycle
    always_comb begin
        state_nxt    = state;
        seq_nxt      = seq;
        dllp_q_nxt   = dllp_q;
        term_nxt     = term_q;
        sym_nxt      = '{data: D_IDLE, k: 1'b0};
        ack_nxt      = 1'b0;
        skp_sent_nxt = 1'b0;
        under_nxt    = 1'b0;
        skp_taken    = 1'b0;

        cur_c = state;
        if (state == ST_IDLE) begin
            if (skp_pending)     cur_c = ST_SKP_OS;
            else if (dllp_valid) cur_c = ST_DLLP;
            else if (tlp_valid)  cur_c = ST_TLP_STP;
        end

        case (cur_c)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_SKP_OS: begin
                if (seq == '0) begin
                    sym_nxt      = '{data: K_COM, k: 1'b1};
                    skp_sent_nxt = 1'b1;
                    skp_taken    = 1'b1;
                end else begin
                    sym_nxt = '{data: K_SKP, k: 1'b1};
                end
                if (seq == SKP_LAST) begin
                    seq_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    seq_nxt   = seq + SEQ_W'(1);
                    state_nxt = ST_SKP_OS;
                end
            end
            ST_DLLP: begin
                if (seq == '0) begin
                    sym_nxt    = '{data: K_SDP, k: 1'b1};
                    dllp_q_nxt = dllp_data;
                    ack_nxt    = 1'b1;
                end else if (seq == DLLP_LAST) begin
                    sym_nxt = '{data: K_END, k: 1'b1};
                end else begin
                    sym_nxt    = '{data: dllp_q[DLLP_W-1 -: SYM_W], k: 1'b0};
                    dllp_q_nxt = {dllp_q[DLLP_W-SYM_W-1:0], SYM_W'(0)};
                end
                if (seq == DLLP_LAST) begin
                    seq_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    seq_nxt   = seq + SEQ_W'(1);
                    state_nxt = ST_DLLP;
                end
            end
            ST_TLP_STP: begin
                sym_nxt   = '{data: K_STP, k: 1'b1};
                state_nxt = ST_TLP_DATA;
            end
            ST_TLP_DATA: begin
                if (tlp_valid) begin
                    sym_nxt = '{data: tlp_data, k: 1'b0};
                    if (tlp_last) begin
                        term_nxt  = tlp_bad ? K_EDB : K_END;
                        state_nxt = ST_TLP_END;
                    end
                end else begin
                    sym_nxt   = '{data: K_EDB, k: 1'b1};
                    under_nxt = 1'b1;
                    state_nxt = ST_TLP_FLUSH;
                end
            end
            ST_TLP_END: begin
                sym_nxt   = '{data: term_q, k: 1'b1};
                state_nxt = ST_IDLE;
            end
            ST_TLP_FLUSH: begin
                if (tlp_valid && tlp_last) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                seq_nxt   = '0;
            end
        endcase

        // Link down abandons whatever is in flight and forces idle
        if (!link_up) begin
            state_nxt    = ST_IDLE;
            seq_nxt      = '0;
            sym_nxt      = '{data: D_IDLE, k: 1'b0};
            ack_nxt      = 1'b0;
            skp_sent_nxt = 1'b0;
            under_nxt    = 1'b0;
            skp_taken    = 1'b0;
        end

        ready_nxt = (state_nxt == ST_TLP_DATA) || (state_nxt == ST_TLP_FLUSH);
    end

    // Scheduler state and packet context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            seq    <= '0;
            dllp_q <= '0;
            term_q <= K_END;
        end else begin
            state  <= state_nxt;
            seq    <= seq_nxt;
            dllp_q <= dllp_q_nxt;
            term_q <= term_nxt;
        end
    end

    // Registered outputs towards the encoder and the sources
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data      <= D_IDLE;
            tx_k         <= 1'b0;
            tlp_ready    <= 1'b0;
            dllp_ack     <= 1'b0;
            skp_sent     <= 1'b0;
            tlp_underrun <= 1'b0;
        end else begin
            tx_data      <= sym_nxt.data;
            tx_k         <= sym_nxt.k;
            tlp_ready    <= ready_nxt;
            dllp_ack     <= ack_nxt;
            skp_sent     <= skp_sent_nxt;
            tlp_underrun <= under_nxt;
        end
    end

endmodule

// File: tb/tb_pcie_tx_link_scheduler.sv
// Directed bench for pcie_tx_link_scheduler: vector table plus SKP timing sequences.
module tb_pcie_tx_link_scheduler;

    localparam int unsigned SKP_INTERVAL = 1180;
    localparam int unsigned SKP_COUNT    = 3;

    logic        clk, rst, link_up;
    logic        tlp_valid, tlp_last, tlp_bad, tlp_ready;
    logic [7:0]  tlp_data;
    logic        dllp_valid, dllp_ack;
    logic [47:0] dllp_data;
    logic [7:0]  tx_data;
    logic        tx_k, skp_sent, tlp_underrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    pcie_tx_link_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_COUNT    (SKP_COUNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .link_up      (link_up),
        .tlp_valid    (tlp_valid),
        .tlp_data     (tlp_data),
        .tlp_last     (tlp_last),
        .tlp_bad      (tlp_bad),
        .tlp_ready    (tlp_ready),
        .dllp_valid   (dllp_valid),
        .dllp_data    (dllp_data),
        .dllp_ack     (dllp_ack),
        .tx_data      (tx_data),
        .tx_k         (tx_k),
        .skp_sent     (skp_sent),
        .tlp_underrun (tlp_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs held for one cycle, registered outputs expected after that edge
    typedef struct {
        logic        rb;
        logic        lu, tv;
        logic [7:0]  td;
        logic        tl, tb, dv;
        logic [47:0] dd;
        logic [7:0]  ed;
        logic        ek, er, ea, es, eu;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic rb, input logic lu, input logic tv, input logic [7:0] td,
                        input logic tl, input logic tb, input logic dv, input logic [47:0] dd,
                        input logic [7:0] ed, input logic ek, input logic er, input logic ea,
                        input logic es, input logic eu);
        vec_t v;
        v.rb = rb; v.lu = lu; v.tv = tv; v.td = td; v.tl = tl; v.tb = tb;
        v.dv = dv; v.dd = dd; v.ed = ed; v.ek = ek; v.er = er; v.ea = ea;
        v.es = es; v.eu = eu;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d at cyc %0d: got 0x%h want 0x%h", nm, idx, cyc, act, exp);
        end
    endtask

    // Checks {tx_data, tx_k, skp_sent, tlp_underrun}
    task automatic exp_sym(input string nm, input int idx, input logic [7:0] d, input logic k,
                           input logic s, input logic u);
        chk(nm, idx, 16'({tx_data, tx_k, skp_sent, tlp_underrun}), 16'({d, k, s, u}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input logic lu, input logic tv, input logic [7:0] td, input logic tl,
                          input logic tb, input logic dv, input logic [47:0] dd);
        link_up = lu; tlp_valid = tv; tlp_data = td; tlp_last = tl; tlp_bad = tb;
        dllp_valid = dv; dllp_data = dd;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 48'h0);
        rst = 1'b1;
        #1;
        chk("reset_outputs{data,k,rdy,ack,skp,und}", 0,
            16'({tx_data, tx_k, tlp_ready, dllp_ack, skp_sent, tlp_underrun}), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Holds idle inputs with the link up until cyc reaches target, counting non-idle symbols
    task automatic idle_until(input string nm, input int target);
        int bad;
        bad = 0;
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 48'h0);
        while (cyc < target) begin
            tick();
            if ({tx_data, tx_k, skp_sent} !== 10'h000) bad++;
        end
        chk(nm, target, 16'(bad), 16'd0);
    endtask

    // Sends an nb-byte TLP (bytes 1,2,3,...) and checks STP, data and terminator
    task automatic send_tlp(input int nb, input logic bad);
        set_in(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 48'h0);
        tick();
        exp_sym("tlp_stp", nb, 8'hFB, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) begin
            tlp_data = 8'(i + 1);
            tlp_last = (i == nb - 1);
            tlp_bad  = bad && (i == nb - 1);
            chk("tlp_ready_byte", i, 16'(tlp_ready), 16'd1);
            tick();
            exp_sym("tlp_byte", i, 8'(i + 1), 1'b0, 1'b0, 1'b0);
        end
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 48'h0);
        chk("tlp_ready_after_last", nb, 16'(tlp_ready), 16'd0);
        tick();
        exp_sym("tlp_term", nb, bad ? 8'hFE : 8'hFD, 1'b1, 1'b0, 1'b0);
    endtask

    // COM with skp_sent, then SKP_COUNT SKP symbols
    task automatic expect_skp_os(input int tag);
        tick();
        exp_sym("skp_com", tag, 8'hBC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < int'(SKP_COUNT); i++) begin
            tick();
            exp_sym("skp_sym", tag * 10 + i, 8'h1C, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int n;
        int idle_bad;
        logic found;

        rst = 1'b1;
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 48'h0);
        #2;
        do_reset();

        // Good 4-byte TLP
        addv(1,1,0,8'h00,0,0,0,48'h0, 8'h00,0,0,0,0,0);
        addv(0,1,1,8'h11,0,0,0,48'h0, 8'hFB,1,1,0,0,0);
        addv(0,1,1,8'h11,0,0,0,48'h0, 8'h11,0,1,0,0,0);
        addv(0,1,1,8'h22,0,0,0,48'h0, 8'h22,0,1,0,0,0);
        addv(0,1,1,8'h33,0,0,0,48'h0, 8'h33,0,1,0,0,0);
        addv(0,1,1,8'h44,1,0,0,48'h0, 8'h44,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'hFD,1,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h00,0,0,0,0,0);
        // Nullified 4-byte TLP
        addv(1,1,0,8'h00,0,0,0,48'h0, 8'h00,0,0,0,0,0);
        addv(0,1,1,8'h11,0,0,0,48'h0, 8'hFB,1,1,0,0,0);
        addv(0,1,1,8'h11,0,0,0,48'h0, 8'h11,0,1,0,0,0);
        addv(0,1,1,8'h22,0,0,0,48'h0, 8'h22,0,1,0,0,0);
        addv(0,1,1,8'h33,0,0,0,48'h0, 8'h33,0,1,0,0,0);
        addv(0,1,1,8'h44,1,1,0,48'h0, 8'h44,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'hFE,1,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h00,0,0,0,0,0);
        // ACK DLLP and TLP requested together: DLLP first, then TLP
        addv(1,1,1,8'hAA,1,0,1,48'h00_00_01_AB_CD_EF, 8'h5C,1,0,1,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'h00,0,0,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'h00,0,0,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'h01,0,0,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'hAB,0,0,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'hCD,0,0,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'hEF,0,0,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'hFD,1,0,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'hFB,1,1,0,0,0);
        addv(0,1,1,8'hAA,1,0,0,48'h0, 8'hAA,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'hFD,1,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h00,0,0,0,0,0);
        // Underrun after byte 2 of 6, remaining bytes flushed
        addv(1,1,1,8'h11,0,0,0,48'h0, 8'hFB,1,1,0,0,0);
        addv(0,1,1,8'h11,0,0,0,48'h0, 8'h11,0,1,0,0,0);
        addv(0,1,1,8'h22,0,0,0,48'h0, 8'h22,0,1,0,0,0);
        addv(0,1,0,8'h33,0,0,0,48'h0, 8'hFE,1,1,0,0,1);
        addv(0,1,1,8'h33,0,0,0,48'h0, 8'h00,0,1,0,0,0);
        addv(0,1,1,8'h44,0,0,0,48'h0, 8'h00,0,1,0,0,0);
        addv(0,1,1,8'h55,0,0,0,48'h0, 8'h00,0,1,0,0,0);
        addv(0,1,1,8'h66,1,0,0,48'h0, 8'h00,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h00,0,0,0,0,0);
        // Link drop mid-DLLP: no END, held request not acked while down, restarts from SDP
        addv(1,1,0,8'h00,0,0,1,48'h10_20_30_40_50_60, 8'h5C,1,0,1,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h10,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h20,0,0,0,0,0);
        addv(0,0,0,8'h00,0,0,1,48'h10_20_30_40_50_60, 8'h00,0,0,0,0,0);
        addv(0,0,0,8'h00,0,0,1,48'h10_20_30_40_50_60, 8'h00,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,1,48'h10_20_30_40_50_60, 8'h5C,1,0,1,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h10,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'h20,0,0,0,0,0);
        // Link drop mid-TLP: abandoned without terminator, new TLP starts cleanly
        addv(1,1,1,8'h11,0,0,0,48'h0, 8'hFB,1,1,0,0,0);
        addv(0,1,1,8'h11,0,0,0,48'h0, 8'h11,0,1,0,0,0);
        addv(0,0,1,8'h22,0,0,0,48'h0, 8'h00,0,0,0,0,0);
        addv(0,1,1,8'h22,1,0,0,48'h0, 8'hFB,1,1,0,0,0);
        addv(0,1,1,8'h22,1,0,0,48'h0, 8'h22,0,0,0,0,0);
        addv(0,1,0,8'h00,0,0,0,48'h0, 8'hFD,1,0,0,0,0);

        foreach (vq[i]) begin
            if (vq[i].rb) do_reset();
            set_in(vq[i].lu, vq[i].tv, vq[i].td, vq[i].tl, vq[i].tb, vq[i].dv, vq[i].dd);
            tick();
            chk("vec{data,k,rdy,ack,skp,und}", i,
                16'({tx_data, tx_k, tlp_ready, dllp_ack, skp_sent, tlp_underrun}),
                16'({vq[i].ed, vq[i].ek, vq[i].er, vq[i].ea, vq[i].es, vq[i].eu}));
        end

        // First SKP ordered set after link_up with no traffic
        do_reset();
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 48'h0);
        found    = 1'b0;
        idle_bad = 0;
        for (n = 0; n < int'(SKP_INTERVAL) + 20; n++) begin
            tick();
            if (skp_sent) begin
                found = 1'b1;
                break;
            end
            if ({tx_data, tx_k} !== 9'h000) idle_bad++;
        end
        chk("idle_before_first_skp", 0, 16'(idle_bad), 16'd0);
        chk("first_skp_cycle", 0, 16'(n), 16'(SKP_INTERVAL));
        chk("first_skp_found", 0, 16'(found), 16'd1);
        exp_sym("skp_com", 0, 8'hBC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < int'(SKP_COUNT); i++) begin
            tick();
            exp_sym("skp_sym", i, 8'h1C, 1'b1, 1'b0, 1'b0);
        end
        tick();
        exp_sym("idle_after_skp", 0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Second expiry lands inside a 20-byte TLP; SKP follows its END
        idle_until("idle_before_tlp20", 2350);
        send_tlp(20, 1'b0);
        expect_skp_os(1);
        tick();
        exp_sym("idle_after_skp2", 0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Two expiries while blocked by a long TLP yield exactly one SKP OS
        idle_until("idle_before_tlp2400", 2380);
        send_tlp(2400, 1'b0);
        expect_skp_os(2);
        idle_until("no_second_skp", cyc + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_tx_link_scheduler.md
Name: pcie_tx_link_scheduler

Overview:
- Single-lane transmit scheduler between the transaction/data-link layers and the 8b/10b encoder.
- Each cycle it chooses one source (SKP ordered set, DLLP or TLP), frames it with the K-code markers, and emits one symbol per cycle plus a K flag.
- At packet boundaries it applies strict priority SKP > DLLP > TLP.
- When no source is pending it emits logical idle (D0.0).

Parameters:
- SKP_INTERVAL, 1180, symbol clocks between SKP ordered-set requests (counted while link_up=1).
- SKP_COUNT, 3, number of SKP symbols following COM in each SKP ordered set (1..5).

Ports:
- clk  input  1  symbol clock
- rst  input  1  asynchronous, active-high reset
- link_up  input  1  link in L0; low forces idle and clears scheduling state
- tlp_valid  input  1  TLP byte available
- tlp_data  input  8  TLP byte (header/payload/LCRC already appended)
- tlp_last  input  1  final TLP byte
- tlp_bad  input  1  nullify; sampled with the tlp_last beat
- tlp_ready  output  1  scheduler accepts a TLP byte this cycle
- dllp_valid  input  1  DLLP request; held until dllp_ack
- dllp_data  input  48  DLLP bytes incl. CRC16; [47:40] sent first, [47:40] is the dllp_type
- dllp_ack  output  1  one-cycle pulse when the DLLP is captured
- tx_data  output  8  symbol to encoder
- tx_k  output  1  tx_data is a K-code
- skp_sent  output  1  one-cycle pulse with the COM of each SKP ordered set
- tlp_underrun  output  1  one-cycle pulse when a TLP is terminated by underrun

Behaviour:
- Reset values: tx_data=8'h00, tx_k=0, tlp_ready=0, dllp_ack=0, skp_sent=0, tlp_underrun=0. State is IDLE, SKP counter=0, skp_pending=0.
- Outputs tx_data, tx_k, skp_sent and tlp_underrun are registered. A symbol selected in cycle N appears in cycle N+1.
- A TLP byte accepted (tlp_valid&tlp_ready) in cycle N appears on tx_data in cycle N+1.
- SKP counter:
  - Increments every cycle while link_up=1.
  - At SKP_INTERVAL-1 it wraps to 0 and sets skp_pending.
  - A further expiry while skp_pending=1 leaves skp_pending at 1; requests are never queued twice.
  - skp_pending clears in the cycle the SKP_OS state is entered.
- States:
  - IDLE: emit D0.0 (tx_data=8'h00, tx_k=0) unless a source is pending.
    - skp_pending -> SKP_OS.
    - else dllp_valid -> DLLP.
    - else tlp_valid -> TLP_STP.
  - SKP_OS: emit COM (K28.5, 8'hBC, k=1), then SKP_COUNT x SKP (K28.0, 8'h1C, k=1). Then return to IDLE arbitration; a pending source starts in the next cycle with no idle symbol between.
  - DLLP:
    - Emit SDP (K28.2, 8'h5C), then dllp_data bytes 0..5 MSB first (k=0), then END (K29.7, 8'hFD). Total 8 symbols.
    - dllp_data is captured and dllp_ack pulses in the SDP cycle.
  - TLP_STP: emit STP (K27.7, 8'hFB).
  - TLP_DATA:
    - tlp_ready=1 only in this state. Each accepted byte is emitted.
    - On an accepted tlp_last, the terminator is END, or EDB (K30.7, 8'hFE) if tlp_bad=1. Go to TLP_END.
  - TLP_END: emit the terminator, then go to IDLE arbitration.
  - Underrun: tlp_valid=0 in TLP_DATA triggers the following.
    - Emit EDB in the next cycle and pulse tlp_underrun.
    - Go to TLP_FLUSH, where tlp_ready=1 and bytes are discarded (not emitted, idle output) through tlp_last. Then go to IDLE.
- Once started, a packet or ordered set is never preempted by SKP or DLLP. Arbitration happens only at boundaries.
- link_up=0 in any cycle:
  - Next cycle state=IDLE, counter=0, skp_pending=0, tlp_ready=0, output idle.
  - A partially sent TLP/DLLP is abandoned without a terminator. An unacked DLLP stays unacked.
- Simultaneous skp_pending, dllp_valid and tlp_valid in IDLE: emit SKP OS, then DLLP, then TLP, back to back.

Decomposition:
- Shared package (extend the existing types package):
  - K-code constants COM/STP/SDP/END/EDB/SKP with 8-bit values.
  - dllp_type enum.
  - Scheduler state enum.
- One sub-module: pcie_skp_timer (interval counter + pending flag, clear input).

Test Plan:
- Reset, then link_up=1 with no traffic -> tx_data=00/k=0 every cycle. First skp_sent occurs SKP_INTERVAL+1 cycles after link_up, followed by BC,1C,1C,1C with k=1.
- Single 4-byte TLP (11,22,33,44, last on 44, bad=0) -> FB(k), 11,22,33,44, FD(k). tlp_ready high exactly 4 cycles.
- Same TLP with tlp_bad=1 -> terminator FE(k). No tlp_underrun pulse.
- DLLP 48'h00_00_01_AB_CD_EF (ACK) and TLP requested in the same cycle -> 5C(k), 00,00,01,AB,CD,EF, FD(k), then FB(k) for the TLP. dllp_ack pulses once.
- SKP expiry mid-TLP of 20 bytes -> the TLP completes with FD, then BC,1C,1C,1C. No second SKP OS, even if the interval expires twice while blocked.
- Underrun: tlp_valid drops after byte 2 of 6 -> FE(k) with tlp_underrun pulse. Remaining 4 bytes accepted but not emitted. link_up dropped mid-DLLP -> idle next cycle, no FD.
